msrh_sched_alloc_pick: RTL and testbench

MSRH_SCHED_ALLOC_PICK -- requirements
Module: msrh_sched_alloc_pick

---
 rtl/msrh_pkg.sv | 19 +
 rtl/msrh_sched_alloc_pick_if.sv | 34 +++
 rtl/msrh_sched_age_matrix.sv | 51 +++++
 rtl/msrh_sched_alloc_pick_core.sv | 74 +++++++
 rtl/msrh_sched_alloc_pick.sv | 42 ++++
 tb/tb_msrh_sched_alloc_pick.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/msrh_pkg.sv
// Shared types and helpers for the scheduler allocate/pick block.
// Used by both the MSRH_SCHED_OLDEST_PICK_EN and the fixed-priority builds.
package msrh_pkg;

  localparam int ENTRY_MAX = 32;

  // One row of the age matrix, sized for the largest supported scheduler.
  typedef logic [ENTRY_MAX-1:0] age_row_t;

  function automatic int cnt_width(input int entries);
    return $clog2(entries + 1);
  endfunction

  // Isolates the lowest set bit; shared by allocation and fixed-priority pick.
  function automatic age_row_t lsb_onehot(input age_row_t v);
    return v & (~v + age_row_t'(1));
  endfunction

endpackage

// File: rtl/msrh_sched_alloc_pick_if.sv
// Dispatch/issue/release bundle between the scheduler front end and the allocator.
// Identical in both MSRH_SCHED_OLDEST_PICK_EN configurations.
interface msrh_sched_alloc_pick_if
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 8
);

  localparam int CW = cnt_width(ENTRY_SIZE);

  // Dispatch handshake: an instruction is accepted in exactly the cycle where
  // disp_valid && disp_ready; put names the entry it lands in, valid next cycle.
  logic                  disp_valid;
  logic                  disp_ready;
  logic [ENTRY_SIZE-1:0] put;
  logic [ENTRY_SIZE-1:0] entry_ready;
  logic                  stall;
  logic                  pick_valid;
  logic [ENTRY_SIZE-1:0] picked;
  logic [ENTRY_SIZE-1:0] entry_finish;
  logic                  flush_all;
  logic [CW-1:0]         free_cnt;

  modport master (
    output disp_valid, entry_ready, stall, entry_finish, flush_all,
    input  disp_ready, put, pick_valid, picked, free_cnt
  );

  modport slave (
    input  disp_valid, entry_ready, stall, entry_finish, flush_all,
    output disp_ready, put, pick_valid, picked, free_cnt
  );

endinterface

// File: rtl/msrh_sched_age_matrix.sv
// Age matrix and oldest-candidate select for the scheduler.
// Instantiated only when MSRH_SCHED_OLDEST_PICK_EN is defined.
module msrh_sched_age_matrix
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ENTRY_SIZE-1:0] valid,
  input  logic [ENTRY_SIZE-1:0] put,
  input  logic                  flush,
  input  logic [ENTRY_SIZE-1:0] cand,
  output logic [ENTRY_SIZE-1:0] oldest
);

  // older_q[k][j] = 1: entry j was allocated before entry k.
  age_row_t              older_q [ENTRY_SIZE];
  age_row_t              older_d [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] no_older;

  always_comb begin
    for (int k = 0; k < ENTRY_SIZE; k++) begin
      older_d[k] = older_q[k];
      for (int j = 0; j < ENTRY_SIZE; j++) begin
        if (put[j]) older_d[k][j] = 1'b0;
      end
      if (put[k]) older_d[k] = age_row_t'(valid);
      if (flush) older_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ENTRY_SIZE; k++) older_q[k] <= '0;
    end else begin
      for (int k = 0; k < ENTRY_SIZE; k++) older_q[k] <= older_d[k];
    end
  end

  // Stale bits from freed entries are harmless: they are masked by cand.
  always_comb begin
    no_older = '0;
    for (int c = 0; c < ENTRY_SIZE; c++) begin
      no_older[c] = cand[c] & ~(|(older_q[c] & age_row_t'(cand)));
    end
  end

  assign oldest = ENTRY_SIZE'(lsb_onehot(age_row_t'(no_older)));

endmodule

// File: rtl/msrh_sched_alloc_pick_core.sv
// Valid-vector bookkeeping, allocation and pick for the scheduler.
// MSRH_SCHED_OLDEST_PICK_EN selects the age-matrix picker over lowest-index pick.
module msrh_sched_alloc_pick_core
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  msrh_sched_alloc_pick_if.slave bus
);

  localparam int CW = cnt_width(ENTRY_SIZE);

  logic [ENTRY_SIZE-1:0] r_valid;
  logic [ENTRY_SIZE-1:0] free_vec;
  logic [ENTRY_SIZE-1:0] put_vec;
  logic [ENTRY_SIZE-1:0] cand;
  logic [ENTRY_SIZE-1:0] sel;
  logic [ENTRY_SIZE-1:0] picked_vec;
  logic                  disp_ready;
  logic                  pick_valid;
  logic [CW-1:0]         free_cnt;

  // Allocation uses the registered free vector, so a same-cycle finish frees nothing yet.
  assign free_vec   = ~r_valid;
  assign disp_ready = (|free_vec) & ~bus.flush_all;
  assign put_vec    = (bus.disp_valid & disp_ready) ?
                      ENTRY_SIZE'(lsb_onehot(age_row_t'(free_vec))) : '0;

  // The entry being put is still free in r_valid, so it can never be a candidate.
  assign cand       = r_valid & bus.entry_ready;
  assign pick_valid = (|cand) & ~bus.stall & ~bus.flush_all;

`ifdef MSRH_SCHED_OLDEST_PICK_EN
  msrh_sched_age_matrix #(.ENTRY_SIZE(ENTRY_SIZE)) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (r_valid),
    .put    (put_vec),
    .flush  (bus.flush_all),
    .cand   (cand),
    .oldest (sel)
  );
`else
  assign sel = ENTRY_SIZE'(lsb_onehot(age_row_t'(cand)));
`endif

  assign picked_vec = pick_valid ? sel : '0;

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      free_cnt = free_cnt + CW'(free_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (bus.flush_all) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~bus.entry_finish) | put_vec;
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.put        = put_vec;
  assign bus.pick_valid = pick_valid;
  assign bus.picked     = picked_vec;
  assign bus.free_cnt   = free_cnt;

endmodule

// File: rtl/msrh_sched_alloc_pick.sv
// Scheduler entry allocator and issue picker (top, flat ports).
// Define MSRH_SCHED_OLDEST_PICK_EN for oldest-first pick; default is lowest index.
module msrh_sched_alloc_pick
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_disp_valid,
  output logic                            o_disp_ready,
  output logic [ENTRY_SIZE-1:0]           o_put,
  input  logic [ENTRY_SIZE-1:0]           i_entry_ready,
  input  logic                            i_stall,
  output logic                            o_pick_valid,
  output logic [ENTRY_SIZE-1:0]           o_picked,
  input  logic [ENTRY_SIZE-1:0]           i_entry_finish,
  input  logic                            i_flush_all,
  output logic [$clog2(ENTRY_SIZE+1)-1:0] o_free_cnt
);

  msrh_sched_alloc_pick_if #(.ENTRY_SIZE(ENTRY_SIZE)) bus ();

  assign bus.disp_valid   = i_disp_valid;
  assign bus.entry_ready  = i_entry_ready;
  assign bus.stall        = i_stall;
  assign bus.entry_finish = i_entry_finish;
  assign bus.flush_all    = i_flush_all;

  assign o_disp_ready = bus.disp_ready;
  assign o_put        = bus.put;
  assign o_pick_valid = bus.pick_valid;
  assign o_picked     = bus.picked;
  assign o_free_cnt   = bus.free_cnt;

  msrh_sched_alloc_pick_core #(.ENTRY_SIZE(ENTRY_SIZE)) u_core (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .bus   (bus.slave)
  );

endmodule

// File: tb/tb_msrh_sched_alloc_pick.sv
// Bench for msrh_sched_alloc_pick (ENTRY_SIZE=4), either MSRH_SCHED_OLDEST_PICK_EN setting.
// Directed scenarios with literal expectations, then random traffic against a queue model.
module tb_msrh_sched_alloc_pick;

  localparam int ES = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  msrh_sched_alloc_pick_if #(.ENTRY_SIZE(ES)) bus ();

  msrh_sched_alloc_pick #(.ENTRY_SIZE(ES)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_disp_valid   (bus.disp_valid),
    .o_disp_ready   (bus.disp_ready),
    .o_put          (bus.put),
    .i_entry_ready  (bus.entry_ready),
    .i_stall        (bus.stall),
    .o_pick_valid   (bus.pick_valid),
    .o_picked       (bus.picked),
    .i_entry_finish (bus.entry_finish),
    .i_flush_all    (bus.flush_all),
    .o_free_cnt     (bus.free_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: live flags plus allocation order as a queue of indices.
  logic [ES-1:0] m_valid;
  int            order[$];

  task automatic model_clear();
    m_valid = '0;
    order.delete();
  endtask

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < ES; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  function automatic logic m_ready(input logic fl);
    return (m_free_cnt() > 0) && !fl;
  endfunction

  function automatic logic [ES-1:0] m_put(input logic dv, input logic fl);
    logic [ES-1:0] r;
    r = '0;
    if (dv && m_ready(fl)) begin
      for (int i = ES - 1; i >= 0; i--) if (!m_valid[i]) r = ES'(1) << i;
    end
    return r;
  endfunction

  function automatic logic [ES-1:0] m_pick(input logic [ES-1:0] er, input logic st,
                                           input logic fl);
    logic [ES-1:0] c;
    c = m_valid & er;
    if (fl || st || c == '0) return '0;
`ifdef MSRH_SCHED_OLDEST_PICK_EN
    for (int n = 0; n < order.size(); n++) begin
      if (c[order[n]]) return ES'(1) << order[n];
    end
    return '0;
`else
    for (int i = 0; i < ES; i++) if (c[i]) return ES'(1) << i;
    return '0;
`endif
  endfunction

  task automatic model_step();
    logic [ES-1:0] p;
    p = m_put(bus.disp_valid, bus.flush_all);
    if (bus.flush_all) begin
      model_clear();
    end else begin
      for (int i = 0; i < ES; i++) begin
        if (bus.entry_finish[i] && m_valid[i]) begin
          m_valid[i] = 1'b0;
          for (int n = 0; n < order.size(); n++) begin
            if (order[n] == i) begin
              order.delete(n);
              break;
            end
          end
        end
      end
      for (int i = 0; i < ES; i++) begin
        if (p[i]) begin
          m_valid[i] = 1'b1;
          order.push_back(i);
        end
      end
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_disp_ready", 32'(bus.disp_ready), 32'(m_ready(bus.flush_all)));
    check("cmp_put", 32'(bus.put), 32'(m_put(bus.disp_valid, bus.flush_all)));
    check("cmp_picked", 32'(bus.picked), 32'(m_pick(bus.entry_ready, bus.stall, bus.flush_all)));
    check("cmp_pick_valid", 32'(bus.pick_valid),
          32'(m_pick(bus.entry_ready, bus.stall, bus.flush_all) != '0));
    check("cmp_free_cnt", 32'(bus.free_cnt), 32'(m_free_cnt()));
  end

  // Driver tasks
  task automatic drive(input logic dv, input logic [ES-1:0] er, input logic st,
                       input logic [ES-1:0] fin, input logic fl);
    @(posedge clk);
    #1;
    bus.disp_valid   = dv;
    bus.entry_ready  = er;
    bus.stall        = st;
    bus.entry_finish = fin;
    bus.flush_all    = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic flush_now();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [ES-1:0] fin;
    errors = 0;
    checks = 0;
    model_clear();
    rst_n            = 1'b0;
    bus.disp_valid   = 1'b0;
    bus.entry_ready  = '0;
    bus.stall        = 1'b0;
    bus.entry_finish = '0;
    bus.flush_all    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_disp_ready", 32'(bus.disp_ready), 32'd1);
    check("reset_put", 32'(bus.put), 32'd0);
    check("reset_pick_valid", 32'(bus.pick_valid), 32'd0);
    check("reset_picked", 32'(bus.picked), 32'd0);
    check("reset_free_cnt", 32'(bus.free_cnt), 32'd4);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill on consecutive cycles
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2 check("fill_put0", 32'(bus.put), 32'b0001);
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2 check("fill_put1", 32'(bus.put), 32'b0010);
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2 check("fill_put2", 32'(bus.put), 32'b0100);
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2 check("fill_put3", 32'(bus.put), 32'b1000);
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2;
    check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
    check("full_free_cnt", 32'(bus.free_cnt), 32'd0);
    check("full_put", 32'(bus.put), 32'd0);

    // Finish and dispatch together while full
    drive(1'b1, '0, 1'b0, 4'b0100, 1'b0); #2 check("fin_disp_put", 32'(bus.put), 32'b0000);
    drive(1'b1, '0, 1'b0, '0, 1'b0);      #2 check("fin_disp_next", 32'(bus.put), 32'b0100);

    // Stall holds the pick back for one cycle
    drive(1'b0, 4'b0010, 1'b1, '0, 1'b0); #2;
    check("stall_pick_valid", 32'(bus.pick_valid), 32'd0);
    check("stall_picked", 32'(bus.picked), 32'd0);
    drive(1'b0, 4'b0010, 1'b0, '0, 1'b0); #2;
    check("unstall_pick_valid", 32'(bus.pick_valid), 32'd1);
    check("unstall_picked", 32'(bus.picked), 32'b0010);
    flush_now();
    idle(); #2 check("flush_empty", 32'(bus.free_cnt), 32'd4);

    // Flush suppresses allocate and pick with 3 valid entries
    repeat (3) drive(1'b1, '0, 1'b0, '0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, '0, 1'b1); #2;
    check("flush_put", 32'(bus.put), 32'd0);
    check("flush_pick_valid", 32'(bus.pick_valid), 32'd0);
    check("flush_disp_ready", 32'(bus.disp_ready), 32'd0);
    idle(); #2 check("flush_free_cnt", 32'(bus.free_cnt), 32'd4);

    // Reallocated entry 0 is younger than entry 2
    repeat (3) drive(1'b1, '0, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 4'b0001, 1'b0);
    drive(1'b1, '0, 1'b0, '0, 1'b0); #2 check("realloc_put", 32'(bus.put), 32'b0001);
    drive(1'b0, 4'b0101, 1'b0, '0, 1'b0); #2;
`ifdef MSRH_SCHED_OLDEST_PICK_EN
    check("age_picked", 32'(bus.picked), 32'b0100);
`else
    check("age_picked", 32'(bus.picked), 32'b0001);
`endif
    flush_now();

    // Reset mid-operation with two valid entries
    repeat (2) drive(1'b1, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 4'b0011, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_free_cnt", 32'(bus.free_cnt), 32'd4);
    check("rst_mid_pick_valid", 32'(bus.pick_valid), 32'd0);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      fin = '0;
      for (int i = 0; i < ES; i++) fin[i] = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 9) < 7), ES'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0), fin, ($urandom_range(0, 39) == 0));
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
